// File: rtl/dct_1d_if.sv
// Handshake and coefficient-port bundle for the 1-D transform engine.
// The engine sits on the slave side; the producer/consumer pair drives the master side.
interface dct_1d_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_DEPTH  = 8,
    parameter int COEFF_WIDTH = 16
);
    localparam int ROW_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

    logic                              in_valid;
    logic                              in_ready;
    logic                              mode;
    logic [DATA_WIDTH*DATA_DEPTH-1:0]  data_in;
    logic                              out_valid;
    logic                              out_ready;
    logic [DATA_WIDTH*DATA_DEPTH-1:0]  data_out;
    logic                              coeff_wr_en;
    logic [ROW_W-1:0]                  coeff_wr_row;
    logic [COEFF_WIDTH*DATA_DEPTH-1:0] coeff_wr_data;
    logic                              coeff_ready;

    modport master (
        output in_valid, mode, data_in, out_ready, coeff_wr_en, coeff_wr_row, coeff_wr_data,
        input  in_ready, out_valid, data_out, coeff_ready
    );

    modport slave (
        input  in_valid, mode, data_in, out_ready, coeff_wr_en, coeff_wr_row, coeff_wr_data,
        output in_ready, out_valid, data_out, coeff_ready
    );
endinterface

// File: rtl/dct_1d_engine.sv
// Sequential N-point 1-D transform: y = C*x (forward) or C^T*x (inverse), one output
// element per cycle, with round-half-up and saturation to the data width.
module dct_1d_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_DEPTH  = 8,
    parameter int COEFF_WIDTH = 16,
    parameter int FRAC_BITS   = 14
) (
    input  logic     clk,
    input  logic     reset_n,
    dct_1d_if.slave  bus
);
    localparam int K_W    = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_W  = DATA_WIDTH + COEFF_WIDTH + K_W;
    localparam int SUM_W  = ACC_W + 1;
    localparam int BUS_W  = DATA_WIDTH * DATA_DEPTH;

    localparam logic [K_W-1:0]               K_LAST  = K_W'(DATA_DEPTH - 1);
    localparam logic signed [SUM_W-1:0]      ROUND_C = SUM_W'(1'b1) << (FRAC_BITS - 1);
    localparam logic signed [DATA_WIDTH-1:0] Y_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] Y_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]      SAT_MAX = SUM_W'(Y_MAX);
    localparam logic signed [SUM_W-1:0]      SAT_MIN = SUM_W'(Y_MIN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic                          in_ready_r;
    logic                          coeff_ready_r;
    logic                          out_valid_r;
    logic [K_W-1:0]                k_r;
    logic                          mode_r;
    logic [BUS_W-1:0]              x_r;
    logic [BUS_W-1:0]              data_out_r;
    logic signed [COEFF_WIDTH-1:0] coeff_r [DATA_DEPTH][DATA_DEPTH];

    logic                          row_ok_s;
    logic [K_W-1:0]                idx_s;
    logic signed [DATA_WIDTH-1:0]  x_elem_s;
    logic signed [COEFF_WIDTH-1:0] c_elem_s;
    logic signed [PROD_W-1:0]      prod_s;
    logic signed [ACC_W-1:0]       acc_s;
    logic signed [SUM_W-1:0]       sum_s;
    logic signed [SUM_W-1:0]       shr_s;
    logic signed [DATA_WIDTH-1:0]  y_s;

    assign bus.in_ready    = in_ready_r;
    assign bus.coeff_ready = coeff_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.data_out    = data_out_r;

    // Row indices beyond the matrix only exist when the depth is not a power of two.
    generate
        if ((1 << K_W) == DATA_DEPTH) begin : g_row_full
            assign row_ok_s = 1'b1;
        end else begin : g_row_chk
            assign row_ok_s = (bus.coeff_wr_row < K_W'(DATA_DEPTH));
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; in_ready equals "state is IDLE", so in_valid alone accepts.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nxt_s = ST_COMPUTE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (k_r == K_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_COMPUTE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake flags registered from the next state so they mirror state_r exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_r    <= 1'b1;
            coeff_ready_r <= 1'b1;
            out_valid_r   <= 1'b0;
        end else begin
            in_ready_r    <= (state_nxt_s == ST_IDLE);
            coeff_ready_r <= (state_nxt_s == ST_IDLE);
            out_valid_r   <= (state_nxt_s == ST_DONE);
        end
    end

    // Coefficient matrix; a row written on the accept edge is visible to that vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DATA_DEPTH; r++) begin
                for (int n = 0; n < DATA_DEPTH; n++) begin
                    coeff_r[r][n] <= '0;
                end
            end
        end else if (bus.coeff_wr_en && coeff_ready_r && row_ok_s) begin
            for (int n = 0; n < DATA_DEPTH; n++) begin
                coeff_r[bus.coeff_wr_row][n] <= bus.coeff_wr_data[n*COEFF_WIDTH +: COEFF_WIDTH];
            end
        end
    end

    // Full-precision dot product of the captured vector with row or column k.
    always_comb begin
        acc_s    = '0;
        idx_s    = '0;
        x_elem_s = '0;
        c_elem_s = '0;
        prod_s   = '0;
        for (int n = 0; n < DATA_DEPTH; n++) begin
            idx_s    = K_W'(n);
            x_elem_s = x_r[n*DATA_WIDTH +: DATA_WIDTH];
            if (mode_r) begin
                c_elem_s = coeff_r[idx_s][k_r];
            end else begin
                c_elem_s = coeff_r[k_r][idx_s];
            end
            prod_s = x_elem_s * c_elem_s;
            acc_s  = acc_s + ACC_W'(prod_s);
        end
    end

    // Round half toward +inf, drop the fraction, clamp into the data range.
    always_comb begin
        sum_s = SUM_W'(acc_s) + ROUND_C;
        shr_s = sum_s >>> FRAC_BITS;
        y_s   = '0;
        if (shr_s > SAT_MAX) begin
            y_s = Y_MAX;
        end else if (shr_s < SAT_MIN) begin
            y_s = Y_MIN;
        end else begin
            y_s = shr_s[DATA_WIDTH-1:0];
        end
    end

    // Vector capture, element counter and output slots.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_r        <= '0;
            mode_r     <= 1'b0;
            x_r        <= '0;
            data_out_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        x_r    <= bus.data_in;
                        mode_r <= bus.mode;
                        k_r    <= '0;
                    end
                end
                ST_COMPUTE: begin
                    data_out_r[k_r*DATA_WIDTH +: DATA_WIDTH] <= y_s;
                    if (k_r == K_LAST) begin
                        k_r <= '0;
                    end else begin
                        k_r <= k_r + K_W'(1);
                    end
                end
                default: begin
                    k_r <= k_r;
                end
            endcase
        end
    end
endmodule

// File: doc/dct_1d_engine.md
# dct_1d_engine

Sequential, parametrised N-point 1-D transform engine: multiplies an input vector by a loadable signed fixed-point coefficient matrix (forward: C·x, inverse: Cᵀ·x) and produces one output element per cycle with rounding and saturation. It is the next generation of the team's combinational 1-D DCT stage and sits between the block buffer and the row/column transpose in the 2-D DCT/IDCT path. Valid/ready handshakes on both sides; coefficients written row-by-row through a side port.

## Interface
- DATA_WIDTH, 32: signed width of each data element in and out.
- DATA_DEPTH, 8: points per vector (N), ≥2.
- COEFF_WIDTH, 16: signed width of each coefficient.
- FRAC_BITS, 14: fractional bits of coefficients, 1..COEFF_WIDTH-1.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  engine can accept a vector.
- mode  in  1  0 = forward (C·x), 1 = inverse (Cᵀ·x); sampled with the vector.
- data_in  in  DATA_WIDTH*DATA_DEPTH  x[n] = data_in[n*DATA_WIDTH +: DATA_WIDTH], signed.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts result.
- data_out  out  DATA_WIDTH*DATA_DEPTH  y[k] at [k*DATA_WIDTH +: DATA_WIDTH], signed.
- coeff_wr_en  in  1  write one coefficient row.
- coeff_wr_row  in  $clog2(DATA_DEPTH)  row index r.
- coeff_wr_data  in  COEFF_WIDTH*DATA_DEPTH  C[r][n] at [n*COEFF_WIDTH +: COEFF_WIDTH].
- coeff_ready  out  1  coefficient writes accepted this cycle.

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE: in_ready=1, coeff_ready=1. in_valid&&in_ready at an edge: capture data_in and mode, k←0, → COMPUTE. coeff_wr_en with coeff_ready writes row coeff_wr_row at that edge; write and vector acceptance on the same edge are both performed, and the vector uses the newly written row.
- COMPUTE: in_ready=0, coeff_ready=0. Each cycle: acc = Σn x[n]·c(k,n), c = C[k][n] (mode 0) or C[n][k] (mode 1); full-precision width DATA_WIDTH+COEFF_WIDTH+$clog2(DATA_DEPTH). y = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half toward +∞), then saturate to signed DATA_WIDTH. Register y into slot k at the edge; k←k+1. At the edge with k=N-1 → DONE.
- DONE: out_valid=1; data_out held stable until out_valid&&out_ready, then → IDLE. in_ready, coeff_ready = 0.
- coeff_wr_en while coeff_ready=0: write dropped silently, matrix unchanged.
- Out-of-range coeff_wr_row (non-power-of-2 DATA_DEPTH): write dropped.
- data_out slots update only in COMPUTE; otherwise retain last values.

## Timing
- Reset (async assert, any state incl. mid-COMPUTE): state IDLE, k=0, in_ready=1 as soon as reset_n released (combinational from state), coeff_ready=1, out_valid=0, data_out=0, coefficient matrix all zero, captured vector/mode cleared. No partial result is ever presented.
- Latency: acceptance at edge E → out_valid high after edge E+N.
- With out_ready held 1: DONE lasts 1 cycle, IDLE 1 cycle; one vector per N+2 cycles.
- out_ready low in DONE: stall indefinitely, outputs stable, in_valid ignored.
- in_ready, coeff_ready, out_valid are decoded from registered state only (no combinational path from in_valid/out_ready).

## Test plan
- Identity: load C[r][r]=16384, others 0 (FRAC 14); x=[80,70,60,50,40,30,20,10], mode 0 -> y identical, out_valid exactly 8 cycles after accept edge; repeat mode 1 -> same.
- Transpose: C[0][n]=16384 ∀n, other rows 0; x as above; mode 0 -> y=[360,0,0,0,0,0,0,0]; mode 1 -> y=[80,80,80,80,80,80,80,80].
- Rounding/saturation: C[0][0]=8192; x[0]=3 -> y[0]=2; x[0]=-3 -> y[0]=-1. Row 0 all 16384, x all 2147483647 -> y[0]=2147483647; x all -2147483648 -> y[0]=-2147483648.
- Backpressure: out_ready low 20 cycles in DONE -> out_valid and data_out stable, in_ready=0, second in_valid not accepted; out_ready high -> handshake, in_ready=1 next cycle, next vector accepted.
- Coefficient gating: coeff_wr_en to row 0 with zeros during COMPUTE -> dropped, current and next result unchanged; same write in IDLE -> next result y[0]=0.
- Reset mid-op: assert reset_n=0 at k=4 -> out_valid=0, data_out=0, in_ready=1 after release; identity test after reset yields all zeros until coefficients reloaded.
